// File: rtl/demo_scene_sequencer.sv
// Demo scene sequencer: eight effect scenes, each faded in, played and faded out, paced by frame_start.
// Define SCENE_SKIP_EN to compile in the skip button (synchronizer, edge detector, latched request).
module demo_scene_sequencer #(
  parameter int PLAY_FRAMES = 104,
  parameter int FADE_STEP   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       pause,
  input  logic       skip,
  output logic [2:0] scene,
  output logic [6:0] scene_frame,
  output logic [1:0] fade,
  output logic [1:0] state,
  output logic       scene_change
);

  typedef enum logic [1:0] {
    FADE_IN  = 2'd0,
    PLAY     = 2'd1,
    FADE_OUT = 2'd2
  } state_e;

  localparam logic [7:0] FADE_LAST = 8'(FADE_STEP - 1);
  localparam logic [7:0] PLAY_LAST = 8'(PLAY_FRAMES - 1);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [2:0] scene_q;
  logic [6:0] scene_frame_q;
  logic [6:0] scene_frame_d;
  logic [1:0] fade_q;
  logic       scene_change_q;
  logic       accept;
  logic       skip_req;

  assign accept        = frame_start & ~pause;
  assign scene_frame_d = (scene_frame_q == 7'd127) ? scene_frame_q : scene_frame_q + 7'd1;

`ifdef SCENE_SKIP_EN
  logic skip_meta_q;
  logic skip_sync_q;
  logic skip_prev_q;
  logic skip_req_q;

  // Request survives pause; it is spent (acted on or dropped) by the next accepted frame_start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skip_meta_q <= 1'b0;
      skip_sync_q <= 1'b0;
      skip_prev_q <= 1'b0;
      skip_req_q  <= 1'b0;
    end else begin
      skip_meta_q <= skip;
      skip_sync_q <= skip_meta_q;
      skip_prev_q <= skip_sync_q;
      if (skip_sync_q && !skip_prev_q) begin
        skip_req_q <= 1'b1;
      end else if (accept) begin
        skip_req_q <= 1'b0;
      end
    end
  end

  assign skip_req = skip_req_q;
`else
  logic unused_skip;
  assign unused_skip = skip;
  assign skip_req    = 1'b0;
`endif

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= FADE_IN;
      cnt_q          <= '0;
      scene_q        <= '0;
      scene_frame_q  <= '0;
      fade_q         <= 2'd3;
      scene_change_q <= 1'b0;
    end else begin
      scene_change_q <= 1'b0;
      case (state_q)
        FADE_IN: if (accept) begin
          scene_frame_q <= scene_frame_d;
          if (skip_req) begin
            state_q <= FADE_OUT;
            cnt_q   <= '0;
          end else if (cnt_q == FADE_LAST) begin
            cnt_q  <= '0;
            fade_q <= fade_q - 2'd1;
            if (fade_q == 2'd1) state_q <= PLAY;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        PLAY: if (accept) begin
          scene_frame_q <= scene_frame_d;
          if (skip_req || cnt_q == PLAY_LAST) begin
            state_q <= FADE_OUT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        FADE_OUT: if (accept) begin
          if (cnt_q == FADE_LAST) begin
            cnt_q <= '0;
            // Reaching black (also covers a skip taken while still fully black) ends the scene.
            if (fade_q >= 2'd2) begin
              fade_q         <= 2'd3;
              scene_q        <= scene_q + 3'd1;
              scene_frame_q  <= '0;
              state_q        <= FADE_IN;
              scene_change_q <= 1'b1;
            end else begin
              fade_q        <= fade_q + 2'd1;
              scene_frame_q <= scene_frame_d;
            end
          end else begin
            cnt_q         <= cnt_q + 8'd1;
            scene_frame_q <= scene_frame_d;
          end
        end
        default: begin
          state_q        <= FADE_IN;
          cnt_q          <= '0;
          scene_q        <= '0;
          scene_frame_q  <= '0;
          fade_q         <= 2'd3;
          scene_change_q <= 1'b0;
        end
      endcase
    end
  end

  assign scene        = scene_q;
  assign scene_frame  = scene_frame_q;
  assign fade         = fade_q;
  assign state        = state_q;
  assign scene_change = scene_change_q;

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Scoreboard bench for demo_scene_sequencer: segment/elapsed-count reference model, randomized pulses, pause and skip.
`timescale 1ns/1ps
module tb_demo_scene_sequencer;
  localparam int P = 8;
  localparam int F = 2;
`ifdef SCENE_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic pause = 1'b0;
  logic skip = 1'b0;
  logic frame_start2 = 1'b0;

  logic [2:0] scene;       logic [6:0] scene_frame;     logic [1:0] fade;     logic [1:0] state;     logic scene_change;
  logic [2:0] sat_scene;   logic [6:0] sat_scene_frame; logic [1:0] sat_fade; logic [1:0] sat_state; logic sat_scene_change;
  logic [2:0] def_scene;   logic [6:0] def_scene_frame; logic [1:0] def_fade; logic [1:0] def_state; logic def_scene_change;

  always #5 clk = ~clk;

  demo_scene_sequencer #(.PLAY_FRAMES(P), .FADE_STEP(F)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pause(pause), .skip(skip),
    .scene(scene), .scene_frame(scene_frame), .fade(fade), .state(state), .scene_change(scene_change));

  demo_scene_sequencer #(.PLAY_FRAMES(255), .FADE_STEP(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start2), .pause(1'b0), .skip(1'b0),
    .scene(sat_scene), .scene_frame(sat_scene_frame), .fade(sat_fade), .state(sat_state),
    .scene_change(sat_scene_change));

  demo_scene_sequencer dut_def (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start2), .pause(1'b0), .skip(1'b0),
    .scene(def_scene), .scene_frame(def_scene_frame), .fade(def_fade), .state(def_state),
    .scene_change(def_scene_change));

  typedef struct {
    int scene;
    int sframe;
    int fade;
    int state;
    bit change;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_changes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: segment (0 fade-in, 1 play, 2 fade-out), frames elapsed in it, fade at fade-out entry.
  int m_scene, m_seg, m_k, m_f0, m_sframe;
  bit m_pend;

  function automatic void model_reset();
    m_scene = 0; m_seg = 0; m_k = 0; m_f0 = 0; m_sframe = 0; m_pend = 1'b0;
  endfunction

  function automatic int m_fade();
    case (m_seg)
      0:       return 3 - m_k / F;
      1:       return 0;
      default: return (m_f0 + m_k / F > 3) ? 3 : m_f0 + m_k / F;
    endcase
  endfunction

  function automatic bit model_step(input bit acc);
    bit chg;
    chg = 1'b0;
    if (!acc) return 1'b0;
    if (m_pend && m_seg != 2) begin
      m_f0 = m_fade(); m_seg = 2; m_k = 0; m_sframe++;
    end else begin
      m_k++;
      if (m_seg == 0 && m_k == 3 * F) begin
        m_seg = 1; m_k = 0;
      end else if (m_seg == 1 && m_k == P) begin
        m_seg = 2; m_k = 0; m_f0 = 0;
      end else if (m_seg == 2 && m_k == F * ((m_f0 == 3) ? 1 : 3 - m_f0)) begin
        m_scene = (m_scene + 1) % 8; m_seg = 0; m_k = 0; chg = 1'b1;
      end
      m_sframe = chg ? 0 : m_sframe + 1;
    end
    m_pend = 1'b0;
    return chg;
  endfunction

  function automatic exp_t model_now(input bit chg);
    exp_t e;
    e.scene  = m_scene;
    e.sframe = (m_sframe > 127) ? 127 : m_sframe;
    e.fade   = m_fade();
    e.state  = m_seg;
    e.change = chg;
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input bit p, input int gap);
    exp_t e;
    bit   chg;
    pause = p;
    frame_start = 1'b1;
    chg = model_step(!p);
    e = model_now(chg);
    exp_q.push_back(e);
    idle(1);
    frame_start = 1'b0;
    idle(gap);
  endtask

  task automatic press_skip();
    skip = 1'b1;
    idle(4);
    skip = 1'b0;
    idle(4);
    if (SKIP_EN) m_pend = 1'b1;
  endtask

  task automatic pulse2();
    frame_start2 = 1'b1;
    idle(1);
    frame_start2 = 1'b0;
  endtask

  // Monitor: one expected entry per sampled frame_start; scene_change is checked every cycle.
  logic fs_seen = 1'b0;
  always @(posedge clk) fs_seen <= frame_start & rst_n;

  always @(negedge clk) begin
    exp_t e;
    bit   exp_chg;
    exp_chg = 1'b0;
    if (fs_seen) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: DUT output event with no expected entry (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_scene", scene, e.scene);
        check("sb_scene_frame", scene_frame, e.sframe);
        check("sb_fade", fade, e.fade);
        check("sb_state", state, e.state);
        exp_chg = e.change;
      end
    end
    check("sb_scene_change", scene_change, exp_chg);
    if (scene_change) n_changes++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    idle(3);
    check("rst_state", state, 0);
    check("rst_scene", scene, 0);
    check("rst_fade", fade, 3);
    check("rst_scene_frame", scene_frame, 0);
    check("rst_scene_change", scene_change, 0);
    rst_n = 1'b1;
    idle(1);

    // Full scene cycles with directed checkpoints on the first scene.
    n_changes = 0;
    for (int i = 1; i <= 160; i++) begin
      pulse(1'b0, $urandom_range(0, 2));
      if (i == 6 || i == 14 || i == 16 || i == 18 || i == 20) begin
        @(negedge clk); #1;
        case (i)
          6:  begin check("p6_state", state, 1); check("p6_fade", fade, 0); end
          14: check("p14_state", state, 2);
          16: check("p16_fade", fade, 1);
          18: check("p18_fade", fade, 2);
          default: begin
            check("p20_scene", scene, 1); check("p20_fade", fade, 3);
            check("p20_state", state, 0); check("p20_changes", n_changes, 1);
          end
        endcase
      end
    end
    @(negedge clk); #1;
    check("cycle160_changes", n_changes, 8);
    check("cycle160_scene", scene, 0);

    // Pause held across frame_starts in PLAY, then resume.
    for (int i = 0; i < 9; i++) pulse(1'b0, 1);
    for (int i = 0; i < 5; i++) pulse(1'b1, $urandom_range(0, 2));
    for (int i = 0; i < 6; i++) pulse(1'b0, $urandom_range(0, 2));

    // Skip in PLAY at cnt 2, then a second skip during FADE_OUT.
    for (int g = 0; g < 200 && !(m_seg == 1 && m_k == 2); g++) pulse(1'b0, 1);
    @(negedge clk); #1;
    check("reach_play_cnt2", state, 1);
    press_skip();
    pulse(1'b0, 1);
    @(negedge clk); #1;
    check("skip_state", state, SKIP_EN ? 2 : 1);
    check("skip_fade", fade, 0);
    press_skip();
    for (int i = 0; i < 8; i++) pulse(1'b0, 1);

    // Skip request raised during pause in FADE_IN is held until the next accepted frame.
    for (int g = 0; g < 200 && !(m_seg == 0 && m_k == 3); g++) pulse(1'b0, 1);
    pause = 1'b1;
    press_skip();
    for (int i = 0; i < 3; i++) pulse(1'b1, 1);
    pulse(1'b0, 1);
    for (int i = 0; i < 10; i++) pulse(1'b0, 0);

    // Randomized mix of pause, skip and spacing.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) press_skip();
      pulse($urandom_range(0, 3) == 0, $urandom_range(0, 2));
    end

    // Synchronous reset in FADE_OUT with fade 2 on scene 5.
    for (int g = 0; g < 2000 && !(m_seg == 2 && m_fade() == 2 && m_scene == 5); g++) pulse(1'b0, 0);
    @(negedge clk); #1;
    check("pre_rst_state", state, 2);
    check("pre_rst_fade", fade, 2);
    check("pre_rst_scene", scene, 5);
    rst_n = 1'b0;
    idle(1);
    check("mid_rst_state", state, 0);
    check("mid_rst_scene", scene, 0);
    check("mid_rst_fade", fade, 3);
    check("mid_rst_scene_frame", scene_frame, 0);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 25; i++) pulse(1'b0, $urandom_range(0, 1));

    // Saturation (PLAY_FRAMES=255, FADE_STEP=1) and default-parameter 128-frame scene.
    for (int n = 1; n <= 200; n++) begin
      pulse2();
      if (n == 126) check("sat_sf_126", sat_scene_frame, 126);
      if (n == 127) begin
        check("sat_sf_127", sat_scene_frame, 127);
        check("def_127_scene", def_scene, 0);
        check("def_127_state", def_state, 2);
        check("def_127_fade", def_fade, 2);
      end
      if (n == 128) begin
        check("sat_sf_128", sat_scene_frame, 127);
        check("def_128_scene", def_scene, 1);
        check("def_128_fade", def_fade, 3);
        check("def_128_state", def_state, 0);
        check("def_128_sf", def_scene_frame, 0);
        check("def_128_change", def_scene_change, 1);
      end
      if (n == 129) check("def_129_change", def_scene_change, 0);
    end
    check("sat_200_sf", sat_scene_frame, 127);
    check("sat_200_scene", sat_scene, 0);
    check("sat_200_state", sat_state, 1);
    check("sat_200_fade", sat_fade, 0);
    check("sat_200_change", sat_scene_change, 0);
    check("def_200_sf", def_scene_frame, 72);
    check("def_200_state", def_state, 1);

    @(negedge clk); #1;
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
